// File: rtl/mcu_stack_pkg.sv
// Shared stack-pointer types and constants for the MCU core.
// The op enum is reused by the control-unit FSM.
package mcu_stack_pkg;

    localparam int SP_WIDTH    = 8;
    localparam int DEPTH_WIDTH = 9;

    typedef logic [SP_WIDTH-1:0] sp_t;

    localparam sp_t SP_RESET_DEFAULT = 8'h00;

    typedef enum logic [1:0] {
        SP_NOP,
        SP_PUSH,
        SP_POP,
        SP_LOAD
    } sp_op_e;

    // Load beats push/pop; push and pop together cancel out.
    function automatic sp_op_e decode_op(input logic ld, input logic incr, input logic decr);
        if (ld)
            return SP_LOAD;
        else if (decr && !incr)
            return SP_PUSH;
        else if (incr && !decr)
            return SP_POP;
        else
            return SP_NOP;
    endfunction

endpackage

// File: rtl/stack_ptr_unit.sv
// Downward-growing stack pointer for the scratch RAM: supplies SP and SP-1 to
// the address mux, tracks depth and latches sticky overflow/underflow errors.
module stack_ptr_unit
    import mcu_stack_pkg::*;
#(
    parameter sp_t SP_RESET  = SP_RESET_DEFAULT,
    parameter int  MAX_DEPTH = 256
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   SP_LD,
    input  logic                   SP_INCR,
    input  logic                   SP_DECR,
    input  logic [SP_WIDTH-1:0]    DATA_IN,
    input  logic                   ERR_CLR,
    output logic [SP_WIDTH-1:0]    SP_OUT,
    output logic [SP_WIDTH-1:0]    SP_MINUS1,
    output logic [DEPTH_WIDTH-1:0] DEPTH,
    output logic                   STACK_EMPTY,
    output logic                   STACK_FULL,
    output logic                   OVF_ERR,
    output logic                   UNF_ERR
);

    localparam logic [DEPTH_WIDTH-1:0] MAX_D = DEPTH_WIDTH'(MAX_DEPTH);

    sp_t                    sp_q, sp_d;
    logic [DEPTH_WIDTH-1:0] depth_q, depth_d;
    logic [DEPTH_WIDTH-1:0] ld_depth, ld_depth_sat;
    logic                   full, empty;
    logic                   ovf_set, unf_set;
    logic                   ovf_q, unf_q;
    sp_op_e                 op;

    assign op    = decode_op(SP_LD, SP_INCR, SP_DECR);
    assign empty = (depth_q == '0);
    assign full  = (depth_q == MAX_D);

    // Depth implied by a loaded SP is its distance below the reset value.
    assign ld_depth     = {1'b0, sp_t'(SP_RESET - DATA_IN)};
    assign ld_depth_sat = (ld_depth > MAX_D) ? MAX_D : ld_depth;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        sp_d    = sp_q;
        depth_d = depth_q;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        case (op)
            SP_LOAD: begin
                sp_d    = DATA_IN;
                depth_d = ld_depth_sat;
            end
            SP_PUSH: begin
                if (!full) begin
                    sp_d    = sp_q - 8'd1;
                    depth_d = depth_q + 9'd1;
                end else begin
                    ovf_set = 1'b1;
                end
            end
            SP_POP: begin
                if (!empty) begin
                    sp_d    = sp_q + 8'd1;
                    depth_d = depth_q - 9'd1;
                end else begin
                    unf_set = 1'b1;
                end
            end
            SP_NOP: ;
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sp_q    <= SP_RESET;
            depth_q <= '0;
        end else begin
            sp_q    <= sp_d;
            depth_q <= depth_d;
        end
    end

    // Sticky error latches: a new error event outranks a same-cycle clear.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            ovf_q <= 1'b0;
        else if (ovf_set)
            ovf_q <= 1'b1;
        else if (ERR_CLR)
            ovf_q <= 1'b0;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            unf_q <= 1'b0;
        else if (unf_set)
            unf_q <= 1'b1;
        else if (ERR_CLR)
            unf_q <= 1'b0;
    end

    assign SP_OUT      = sp_q;
    assign SP_MINUS1   = sp_q - 8'd1;
    assign DEPTH       = depth_q;
    assign STACK_EMPTY = empty;
    assign STACK_FULL  = full;
    assign OVF_ERR     = ovf_q;
    assign UNF_ERR     = unf_q;

endmodule

// File: tb/tb_stack_ptr_unit.sv
// Bench for stack_ptr_unit: a full-size (256) and a small (4) instance share
// stimulus and are compared against an arithmetic reference model.
module tb_stack_ptr_unit;

    localparam logic [7:0] SP_RST = 8'h00;

    logic       clk;
    logic       rst_n;
    logic       sp_ld, sp_incr, sp_decr, err_clr;
    logic [7:0] data_in;

    logic [7:0] sp_f, m1_f, sp_s, m1_s;
    logic [8:0] dep_f, dep_s;
    logic       emp_f, full_f, ovf_f, unf_f;
    logic       emp_s, full_s, ovf_s, unf_s;

    int n_checks = 0;
    int n_errors = 0;

    int m_sp[2];
    int m_depth[2];
    int m_ovf[2];
    int m_unf[2];
    int m_max[2] = '{256, 4};

    stack_ptr_unit #(.SP_RESET(SP_RST), .MAX_DEPTH(256)) dut_f (
        .CLK(clk), .RST_N(rst_n), .SP_LD(sp_ld), .SP_INCR(sp_incr), .SP_DECR(sp_decr),
        .DATA_IN(data_in), .ERR_CLR(err_clr), .SP_OUT(sp_f), .SP_MINUS1(m1_f),
        .DEPTH(dep_f), .STACK_EMPTY(emp_f), .STACK_FULL(full_f), .OVF_ERR(ovf_f), .UNF_ERR(unf_f)
    );

    stack_ptr_unit #(.SP_RESET(SP_RST), .MAX_DEPTH(4)) dut_s (
        .CLK(clk), .RST_N(rst_n), .SP_LD(sp_ld), .SP_INCR(sp_incr), .SP_DECR(sp_decr),
        .DATA_IN(data_in), .ERR_CLR(err_clr), .SP_OUT(sp_s), .SP_MINUS1(m1_s),
        .DEPTH(dep_s), .STACK_EMPTY(emp_s), .STACK_FULL(full_s), .OVF_ERR(ovf_s), .UNF_ERR(unf_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_sp[i]    = SP_RST;
            m_depth[i] = 0;
            m_ovf[i]   = 0;
            m_unf[i]   = 0;
        end
    endtask

    // One rising edge of the architectural stack behaviour.
    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            bit ovf_ev = 0;
            bit unf_ev = 0;
            if (sp_ld) begin
                m_sp[i]    = data_in;
                m_depth[i] = (int'(SP_RST) - int'(data_in)) & 255;
                if (m_depth[i] > m_max[i]) m_depth[i] = m_max[i];
            end else if (sp_decr && !sp_incr) begin
                if (m_depth[i] < m_max[i]) begin
                    m_sp[i] = (m_sp[i] + 255) % 256;
                    m_depth[i]++;
                end else ovf_ev = 1;
            end else if (sp_incr && !sp_decr) begin
                if (m_depth[i] > 0) begin
                    m_sp[i] = (m_sp[i] + 1) % 256;
                    m_depth[i]--;
                end else unf_ev = 1;
            end
            if (ovf_ev) m_ovf[i] = 1; else if (err_clr) m_ovf[i] = 0;
            if (unf_ev) m_unf[i] = 1; else if (err_clr) m_unf[i] = 0;
        end
    endtask

    task automatic compare_inst(input int i, input logic [7:0] sp, input logic [7:0] m1,
                                input logic [8:0] dep, input logic e, input logic f,
                                input logic o, input logic u);
        string p = (i == 0) ? "big" : "small";
        check({p, " sp"},     32'(sp),  32'(m_sp[i]));
        check({p, " sp_m1"},  32'(m1),  32'((m_sp[i] + 255) % 256));
        check({p, " depth"},  32'(dep), 32'(m_depth[i]));
        check({p, " empty"},  32'(e),   32'(m_depth[i] == 0));
        check({p, " full"},   32'(f),   32'(m_depth[i] == m_max[i]));
        check({p, " ovf"},    32'(o),   32'(m_ovf[i]));
        check({p, " unf"},    32'(u),   32'(m_unf[i]));
    endtask

    task automatic compare_all();
        compare_inst(0, sp_f, m1_f, dep_f, emp_f, full_f, ovf_f, unf_f);
        compare_inst(1, sp_s, m1_s, dep_s, emp_s, full_s, ovf_s, unf_s);
    endtask

    task automatic step(input bit ld, input bit incr, input bit decr,
                        input logic [7:0] din, input bit clr);
        sp_ld   = ld;
        sp_incr = incr;
        sp_decr = decr;
        data_in = din;
        err_clr = clr;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle();
        step(0, 0, 0, 8'h00, 0);
    endtask

    // Assert reset between edges, with strobes possibly still active.
    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        @(negedge clk);
        @(negedge clk);
        compare_all();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n   = 1'b1;
        sp_ld   = 0;
        sp_incr = 0;
        sp_decr = 1;
        data_in = 8'h00;
        err_clr = 0;
        model_reset();

        do_reset();
        check("rst sp",    32'(sp_f),  32'h00);
        check("rst sp_m1", 32'(m1_f),  32'hFF);
        check("rst empty", 32'(emp_f), 32'h1);
        idle();

        step(0, 0, 1, 8'h00, 0); check("push1 sp", 32'(sp_f), 32'hFF);
        step(0, 0, 1, 8'h00, 0); check("push2 sp", 32'(sp_f), 32'hFE);
        step(0, 0, 1, 8'h00, 0); check("push3 sp", 32'(sp_f), 32'hFD);
        check("push3 depth", 32'(dep_f), 32'd3);
        check("push3 sp_m1", 32'(m1_f), 32'hFC);
        repeat (3) step(0, 1, 0, 8'h00, 0);
        check("pop3 sp", 32'(sp_f), 32'h00);
        check("pop3 empty", 32'(emp_f), 32'h1);

        step(0, 1, 0, 8'h00, 0);
        check("unf sp", 32'(sp_f), 32'h00);
        check("unf set", 32'(unf_f), 32'h1);
        repeat (5) idle();
        check("unf sticky", 32'(unf_f), 32'h1);
        step(0, 0, 0, 8'h00, 1);
        check("unf cleared", 32'(unf_f), 32'h0);

        do_reset();
        repeat (4) step(0, 0, 1, 8'h00, 0);
        check("small full4 ovf", 32'(ovf_s), 32'h0);
        step(0, 0, 1, 8'h00, 0);
        check("small sp", 32'(sp_s), 32'hFC);
        check("small depth", 32'(dep_s), 32'd4);
        check("small full", 32'(full_s), 32'h1);
        check("small ovf", 32'(ovf_s), 32'h1);
        step(0, 0, 1, 8'h00, 1);
        check("small ovf set beats clr", 32'(ovf_s), 32'h1);

        step(0, 0, 0, 8'h00, 1);
        step(1, 0, 1, 8'hF0, 0);
        check("load sp", 32'(sp_f), 32'hF0);
        check("load depth", 32'(dep_f), 32'd16);
        check("load no ovf", 32'(ovf_f), 32'h0);
        step(0, 1, 1, 8'h00, 0);
        check("incr+decr sp", 32'(sp_f), 32'hF0);

        step(1, 0, 0, 8'h01, 0);
        check("load01 depth", 32'(dep_f), 32'd255);
        step(0, 0, 1, 8'h00, 0);
        check("p256 sp", 32'(sp_f), 32'h00);
        check("p256 depth", 32'(dep_f), 32'd256);
        check("p256 full", 32'(full_f), 32'h1);
        step(0, 0, 1, 8'h00, 0);
        check("p257 ovf", 32'(ovf_f), 32'h1);
        check("p257 sp", 32'(sp_f), 32'h00);

        for (int n = 0; n < 3000; n++) begin
            int  r   = $urandom_range(0, 99);
            int  p   = $urandom_range(0, 9);
            bit  ld  = (r < 6);
            bit  inc = (p >= 5 && p <= 8);
            bit  dec = (p <= 4 || p == 8);
            bit  clr = ($urandom_range(0, 15) == 0);
            logic [7:0] d = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 255))
                                                        : 8'($urandom_range(0, 6) + 250);
            if ($urandom_range(0, 599) == 0)
                do_reset();
            else
                step(ld, inc, dec, d, clr);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
